tpu_sequencer: RTL and testbench

Top-level operation sequencer for the tiny TPU. It drives a single matrix-multiply pass through the operand loader and systolic array in a fixed order: clear accumulators, serial operand load, transfer and compute, result capture, and serial result readout. It sits between the host pin interface and the `input_control` loader and PE array, and produces `load_en`, `init` and the accumulator clear.

---
 rtl/tpu_sequencer.sv | 91 +++++++++
 tb/tb_tpu_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// Operation sequencer for the tiny TPU: clear, serial load, init, compute, capture, serial readout.
// Moore outputs decoded from registered state; abort or rst returns to IDLE with counter and shift register cleared.
module tpu_sequencer #(
  parameter int D_W      = 8,
  parameter int N        = 2,
  parameter int ACC_W    = 16,
  parameter int COMP_CYC = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N*N*ACC_W-1:0] res_flat,
  output logic                 acc_clr,
  output logic                 load_en,
  output logic                 init,
  output logic                 data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int L     = N * N * D_W;
  localparam int R     = N * N * ACC_W;
  localparam int MAX_A = (L > COMP_CYC) ? L : COMP_CYC;
  localparam int MAXC  = (MAX_A > R) ? MAX_A : R;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0] L_LD = CW'(L - 1);
  localparam logic [CW-1:0] C_LD = CW'(COMP_CYC - 1);
  localparam logic [CW-1:0] R_LD = CW'(R - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_GAP, S_INIT, S_COMPUTE, S_CAPTURE, S_SHIFT, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [R-1:0]    shreg;
  logic            cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start && !abort) state_nx = S_CLEAR;
      S_CLEAR:   state_nx = S_LOAD;
      S_LOAD:    if (cnt_zero) state_nx = S_GAP;
      S_GAP:     state_nx = S_INIT;
      S_INIT:    state_nx = S_COMPUTE;
      S_COMPUTE: if (cnt_zero) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_SHIFT;
      S_SHIFT:   if (cnt_zero) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // The counter is reloaded on the cycle before each timed phase, so it hits zero on that phase's last cycle.
  always_ff @(posedge clk) begin
    if (rst || (abort && state != S_IDLE)) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_CLEAR:   cnt <= L_LD;
        S_INIT:    cnt <= C_LD;
        S_CAPTURE: cnt <= R_LD;
        default:   if (!cnt_zero) cnt <= cnt - CW'(1);
      endcase
      if (state == S_CAPTURE)    shreg <= res_flat;
      else if (state == S_SHIFT) shreg <= {1'b0, shreg[R-1:1]};
    end
  end

  assign acc_clr    = (state == S_CLEAR);
  assign load_en    = (state == S_LOAD);
  assign init       = (state == S_INIT);
  assign data_valid = (state == S_SHIFT);
  assign data_out   = (state == S_SHIFT) && shreg[0];
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer at default parameters; every output is checked each cycle against hand-derived op timing.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [63:0] res_flat;
  logic        acc_clr, load_en, init, data_out, data_valid, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  tpu_sequencer #(.D_W(8), .N(2), .ACC_W(16), .COMP_CYC(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .res_flat   (res_flat),
    .acc_clr    (acc_clr),
    .load_en    (load_en),
    .init       (init),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int d, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s d=%0d observed=%0b expected=%0b", tag, d, got, exp);
    end
  endtask

  // d is the cycle offset from the accepted start (start in d=0); d<0 means no operation in flight.
  task automatic check_all(input int d, input logic [63:0] val, input bit killed);
    bit   live;
    logic exp_do;
    live   = !killed && d >= 0;
    exp_do = (live && d >= 43 && d <= 106) ? val[d-43] : 1'b0;
    chk("acc_clr",    d, acc_clr,    live && d == 1);
    chk("load_en",    d, load_en,    live && d >= 2 && d <= 33);
    chk("init",       d, init,       live && d == 35);
    chk("data_valid", d, data_valid, live && d >= 43 && d <= 106);
    chk("data_out",   d, data_out,   exp_do);
    chk("done",       d, done,       live && d == 107);
    chk("busy",       d, busy,       live && d >= 1 && d <= 107);
  endtask

  task automatic do_op(input logic [63:0] val, input bit noise, input int kill_d,
                       input bit use_rst, input int last_d);
    for (int d = 0; d <= last_d; d++) begin
      start    = (d == 0) || (noise && (d == 10 || d == 40 || d == 107));
      abort    = !use_rst && (d == kill_d);
      rst      = use_rst && (d == kill_d);
      res_flat = (d == 42) ? val : ((d == 43) ? 64'h0 : ~val);
      check_all(d, val, kill_d >= 0 && d > kill_d);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      check_all(-1, 64'h0, 1'b0);
      step();
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    res_flat = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all(-1, 64'h0, 1'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    idle_check(3);

    // Single op with the reference readout value
    do_op(64'h0123_4567_89AB_CDEF, 1'b0, -1, 1'b0, 107);
    idle_check(2);

    // Abort mid-LOAD, then a clean op
    do_op(64'hDEAD_BEEF_0000_FFFF, 1'b0, 20, 1'b0, 30);
    idle_check(2);
    do_op(64'h8000_0000_0000_0001, 1'b0, -1, 1'b0, 107);

    // Back-to-back: next start lands in the IDLE cycle right after DONE
    do_op(64'hA5A5_5A5A_F00F_0FF0, 1'b0, -1, 1'b0, 107);

    // Stray starts in LOAD, COMPUTE and DONE are ignored
    do_op(64'h1357_9BDF_2468_ACE0, 1'b1, -1, 1'b0, 107);
    idle_check(3);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    idle_check(3);

    // rst in the middle of SHIFT, then a full op
    do_op(64'hFFFF_0000_FFFF_0000, 1'b0, 50, 1'b1, 56);
    idle_check(2);
    do_op(64'h0F0F_F0F0_3C3C_C3C3, 1'b0, -1, 1'b0, 107);
    idle_check(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
